fetch_stage: RTL
================

Name: fetch_stage

Overview:
Parametrised instruction-fetch front end for the pipelined successor of the single-cycle MIPS core. It holds the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned {pc, instr} pairs are buffered in a small FIFO that feeds the decode stage under stall backpressure. Branch/jump redirects flush the buffer and any in-flight fetch.

Parameters:
XLEN, 32, width of PC and instruction words
RESET_PC, 32'h0000_0000, fetch address after reset
PC_STEP, 4, sequential PC increment in bytes
QDEPTH, 2, fetch-buffer entries; power of 2, >=2

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  core enable; sampled high once, then sticky until reset
imem_req_o  out  1  fetch request
imem_addr_o  out  XLEN  fetch address; stable while req high and not acked
imem_ack_i  in  1  request accepted and data valid this cycle (may assert in the first req cycle)
imem_data_i  in  XLEN  instruction word, valid with ack
redirect_i  in  1  taken branch/jump from later stage
redirect_pc_i  in  XLEN  redirect target
stall_i  in  1  decode not accepting
inst_valid_o  out  1  FIFO head valid
inst_o  out  XLEN  instruction at head
pc_o  out  XLEN  address of inst_o
pc_next_o  out  XLEN  pc_o + PC_STEP

Behaviour:
- Reset (rst_i low, asynchronous): fetch_pc=RESET_PC, FIFO empty, started=0, state=IDLE. imem_req_o=0, inst_valid_o=0, inst_o=0, pc_o=0, pc_next_o=PC_STEP, imem_addr_o=RESET_PC.
- State machine:
  - IDLE: req=0. When start_i=1 -> FETCH next edge.
  - FETCH: req=1 iff count<QDEPTH; addr=fetch_pc.
    - On ack without redirect: push {fetch_pc, imem_data_i}, fetch_pc+=PC_STEP.
  - DRAIN: entered on redirect while req=1 and ack=0. req stays 1 and addr stays unchanged. On ack, data is discarded -> FETCH at the redirect target.
- Request gating: req is computed from the registered count only. A same-cycle pop does not free a slot for that cycle.
- Pop: occurs when inst_valid_o & ~stall_i. Push and pop in the same cycle keep count unchanged.
- Latency: request acked in cycle t -> inst_valid_o in cycle t+1 (registered FIFO). Minimum request-to-decode latency is 1 cycle. Throughput is 1 instr/cycle with single-cycle acks.
- Redirect (any state except IDLE), cycle t:
  - FIFO flushed at edge t; inst_valid_o=0 in t+1. Pop and push in cycle t are ignored.
  - If no req was pending, or ack=1 in t (data discarded): fetch_pc=redirect_pc_i with bits [1:0] forced to 0, and req for the new address appears in t+1.
  - If req was pending without ack -> DRAIN; the target is held in a register.
  - A second redirect while in DRAIN overwrites the held target.
- Redirect and stall in the same cycle: redirect wins.
- Redirect in IDLE: only updates fetch_pc.
- fetch_pc wraps modulo 2^XLEN with no error.
- start_i after started: no effect.
- Mid-operation reset drops any in-flight request. start_i must be re-asserted after reset.

Decomposition:
- fetch_pkg: state enum (IDLE, FETCH, DRAIN), default XLEN/PC_STEP constants, fetch-entry struct {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO, parameters DEPTH and WIDTH(=2*XLEN); ports push, pop, flush, full, empty, count, head.
- Top level: FSM, PC logic, redirect-target register.

Test Plan:
1. Reset, then start_i=0 for 5 cycles -> imem_req_o=0 throughout. Pulse start_i -> next cycle req=1, addr=0x0.
2. Ack every cycle returning 0x1000+pc, stall_i=0 -> inst_valid_o continuous from cycle after first ack; pc_o = 0,4,8,...; inst_o = 0x1000,0x1004,...; pc_next_o = pc_o+4.
3. QDEPTH=2, stall_i=1 for 6 cycles -> exactly 2 acks pushed, then req=0. Release stall -> pc_o 0x0,0x4 delivered in order, then fetch resumes at 0x8 with no loss or duplication.
4. FIFO holding 2 entries, redirect_i=1 with redirect_pc_i=0x43 -> inst_valid_o=0 next cycle. Next req addr=0x40; first delivered pc_o=0x40.
5. Req to 0x10 pending, ack withheld, redirect to 0x80. Ack arrives 3 cycles later with 0xDEADBEEF -> addr held at 0x10 until ack, 0xDEADBEEF never output, next req addr=0x80.
6. rst_i driven low between clock edges during streaming -> req and inst_valid_o go 0 immediately, addr=RESET_PC. After release, no req until start_i re-asserted.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_e;

    localparam int unsigned XLEN_DEFAULT    = 32;
    localparam int unsigned PC_STEP_DEFAULT = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered fetch buffer; head is a flop output so decode sees data one
// cycle after the push. Flush clears occupancy in a single edge.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC sequencing, imem req/ack handshake and a
// decoupling buffer toward decode; redirects flush buffered and in-flight work.
//
// state | meaning
// IDLE  | core not started, no requests issued
// FETCH | requesting sequential words while the buffer has room
// DRAIN | waiting out a request orphaned by a redirect; target held
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = PC_STEP_DEFAULT,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            stall_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_next_o
);

    localparam int unsigned     CW         = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0]   QDEPTH_C   = CW'(QDEPTH);
    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            started_q, started_d;

    logic            imem_req;
    logic            fifo_push, fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [2*XLEN-1:0] fifo_head;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc_i & ALIGN_MASK;

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i ({fetch_pc_q, imem_data_i}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (fifo_head)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        started_d  = started_q;
        imem_req   = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_i) fetch_pc_d = redirect_target;
                if (start_i && !started_q) begin
                    started_d = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                // gated on registered occupancy only; a same-cycle pop frees nothing
                imem_req = (fifo_count < QDEPTH_C);
                fifo_pop = !fifo_empty && !stall_i && !redirect_i;
                if (redirect_i) begin
                    fifo_flush = 1'b1;
                    if (imem_req && !imem_ack_i) begin
                        state_d  = DRAIN;
                        target_d = redirect_target;
                    end else begin
                        fetch_pc_d = redirect_target;
                    end
                end else if (imem_req && imem_ack_i) begin
                    fifo_push  = !fifo_full;
                    fetch_pc_d = fetch_pc_q + STEP;
                end
            end
            DRAIN: begin
                imem_req = 1'b1;
                if (redirect_i) begin
                    fifo_flush = 1'b1;
                    target_d   = redirect_target;
                end
                if (imem_ack_i) begin
                    state_d    = FETCH;
                    fetch_pc_d = redirect_i ? redirect_target : target_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            target_q   <= RESET_PC;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            started_q  <= started_d;
        end
    end

    assign imem_req_o   = imem_req;
    assign imem_addr_o  = fetch_pc_q;
    assign inst_valid_o = !fifo_empty;
    assign pc_o         = fifo_head[2*XLEN-1:XLEN];
    assign inst_o       = fifo_head[XLEN-1:0];
    assign pc_next_o    = pc_o + STEP;

endmodule
